// File: rtl/img_byte_loader_if.sv
// Byte-stream and image handshake bundle between host, img_byte_loader and the BNN classifier.
interface img_byte_loader_if #(
   parameter int unsigned IMG_PIXELS = 784
);
   logic [7:0]            in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [IMG_PIXELS-1:0] img_out;
   logic                  image_valid;
   logic                  img_ack;

   modport master (
      output in_data, in_valid, img_ack,
      input  in_ready, img_out, image_valid
   );

   modport slave (
      input  in_data, in_valid, img_ack,
      output in_ready, img_out, image_valid
   );
endinterface

// File: rtl/img_byte_loader.sv
// Unpacks a host byte stream into a held binary image for the BNN classifier.
// Optional trailing XOR check byte enabled by defining IMG_CHECKSUM_EN.
module img_byte_loader #(
   parameter  int unsigned IMG_PIXELS    = 784,
   localparam int unsigned BYTES_PER_IMG = IMG_PIXELS / 8,
   localparam int unsigned CNT_W         = 7
) (
   input  logic               clk,
   input  logic               rst_n,
   img_byte_loader_if.slave   bus,
   input  logic               clear,
   output logic [CNT_W-1:0]   byte_count,
   output logic               overrun,
   output logic               checksum_err
);

   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_IMG - 1);
   localparam int unsigned      IDX_W     = CNT_W + 3;

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
      S_FULL  = 2'd1
`ifdef IMG_CHECKSUM_EN
      ,S_CHECK = 2'd2
`endif
   } state_t;

   state_t                state_q, state_nxt;
   logic [CNT_W-1:0]      cnt_q, cnt_nxt;
   logic                  ready_q, ready_nxt;
   logic                  valid_q, valid_nxt;
   logic                  overrun_q, overrun_nxt;
   logic                  wr_en;
   logic                  accept;
   logic [IMG_PIXELS-1:0] img_q;
`ifdef IMG_CHECKSUM_EN
   logic [7:0]            xor_q, xor_nxt;
   logic                  err_q, err_nxt;
`endif

   // MSB of a byte lands on the lowest pixel index of its slot
   function automatic logic [7:0] bit_rev(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
   endfunction

   assign accept = bus.in_valid && ready_q;

   always_comb begin
      state_nxt   = state_q;
      cnt_nxt     = cnt_q;
      ready_nxt   = ready_q;
      valid_nxt   = valid_q;
      overrun_nxt = overrun_q;
      wr_en       = 1'b0;
`ifdef IMG_CHECKSUM_EN
      xor_nxt     = xor_q;
      err_nxt     = 1'b0;
`endif
      if (clear) begin
         state_nxt   = S_FILL;
         cnt_nxt     = '0;
         ready_nxt   = 1'b1;
         valid_nxt   = 1'b0;
         overrun_nxt = 1'b0;
`ifdef IMG_CHECKSUM_EN
         xor_nxt     = '0;
`endif
      end else begin
         if (bus.in_valid && !ready_q) overrun_nxt = 1'b1;
         case (state_q)
            S_FILL: begin
               if (accept) begin
                  wr_en = 1'b1;
`ifdef IMG_CHECKSUM_EN
                  xor_nxt = xor_q ^ bus.in_data;
`endif
                  if (cnt_q == LAST_BYTE) begin
                     cnt_nxt = '0;
`ifdef IMG_CHECKSUM_EN
                     state_nxt = S_CHECK;
`else
                     state_nxt = S_FULL;
                     ready_nxt = 1'b0;
                     valid_nxt = 1'b1;
`endif
                  end else begin
                     cnt_nxt = cnt_q + CNT_W'(1);
                  end
               end
            end
            S_FULL: begin
               if (bus.img_ack) begin
                  state_nxt = S_FILL;
                  ready_nxt = 1'b1;
                  valid_nxt = 1'b0;
               end
            end
`ifdef IMG_CHECKSUM_EN
            // Check byte: release the image on match, drop it on mismatch
            S_CHECK: begin
               if (accept) begin
                  xor_nxt = '0;
                  if (bus.in_data == xor_q) begin
                     state_nxt = S_FULL;
                     ready_nxt = 1'b0;
                     valid_nxt = 1'b1;
                  end else begin
                     state_nxt = S_FILL;
                     err_nxt   = 1'b1;
                  end
               end
            end
`endif
            default: begin
               state_nxt = S_FILL;
               cnt_nxt   = '0;
               ready_nxt = 1'b1;
               valid_nxt = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FILL;
         cnt_q     <= '0;
         ready_q   <= 1'b1;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
`ifdef IMG_CHECKSUM_EN
         xor_q     <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_nxt;
         cnt_q     <= cnt_nxt;
         ready_q   <= ready_nxt;
         valid_q   <= valid_nxt;
         overrun_q <= overrun_nxt;
`ifdef IMG_CHECKSUM_EN
         xor_q     <= xor_nxt;
         err_q     <= err_nxt;
`endif
      end
   end

   // Pixel store: only the slot addressed by the current byte count is written
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         img_q <= '0;
      end else if (wr_en) begin
         img_q[IDX_W'({cnt_q, 3'b000}) +: 8] <= bit_rev(bus.in_data);
      end
   end

   assign bus.in_ready    = ready_q;
   assign bus.image_valid = valid_q;
   assign bus.img_out     = img_q;
   assign byte_count      = cnt_q;
   assign overrun         = overrun_q;
`ifdef IMG_CHECKSUM_EN
   assign checksum_err    = err_q;
`else
   assign checksum_err    = 1'b0;
`endif

endmodule

// File: doc/img_byte_loader.md
Name: img_byte_loader

Overview:
- Upstream stage of the BNN classifier.
- Accepts a byte stream from the host interface and unpacks it into a 28x28 binary image, 8 pixels per byte.
- Presents the image as a held, registered pixel vector with a valid/ack handshake to the classifier.
- Holds the image until the classifier acknowledges it, then rearms for the next image.

Parameters:
- IMG_PIXELS, 784: pixels per image; must be a multiple of 8.
- BYTES_PER_IMG, IMG_PIXELS/8 (98): derived value, not overridden.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_data  input  8  packed pixel byte; MSB = lowest pixel index
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  loader can accept a byte
- clear  input  1  synchronous abort; discards partial image and clears flags
- img_out  output  IMG_PIXELS  pixel vector; bit 0 = pixel 0
- image_valid  output  1  img_out holds a complete image
- img_ack  input  1  consumer has taken the image
- byte_count  output  7  bytes accepted so far in the current image
- overrun  output  1  sticky: byte offered while the loader was full
- checksum_err  output  1  one-cycle pulse on checksum mismatch (optional feature)

Behaviour:
- Reset values: in_ready=1, image_valid=0, byte_count=0, overrun=0, checksum_err=0, img_out all zeros, state FILL.
- Reset is asynchronous and can occur at any point, including mid-image.
- Transfer rule: a byte is accepted on a rising edge where in_valid && in_ready.
- Pixel mapping: byte k, bit b maps to img_out[8k + (7-b)].
- FILL state:
  - in_ready=1.
  - Each accepted byte is written to its slot and byte_count increments.
  - When byte BYTES_PER_IMG-1 is accepted, the next state is FULL (or CHECK when the optional feature is compiled in) and byte_count returns to 0.
- FULL state:
  - in_ready=0, image_valid=1.
  - img_out is stable and unchanged.
- Latency: the last data byte accepted at edge N gives image_valid=1 from edge N onward, so the consumer sees it in cycle N+1. There is no combinational path from in_data to img_out.
- Handshake:
  - img_ack is only meaningful while image_valid=1. If sampled high in FULL, image_valid drops at that edge and the state returns to FILL with in_ready=1.
  - A byte offered in the same cycle as the ack is not accepted, because in_ready was 0 that cycle.
  - img_ack while not FULL is ignored.
- Overrun:
  - in_valid=1 while in_ready=0 sets overrun=1. The byte is dropped and the image is unaffected.
  - overrun stays set until clear or reset.
- clear:
  - Takes effect on the next edge and has priority over transfer and img_ack in the same cycle.
  - Result: state FILL, byte_count=0, image_valid=0, overrun=0.
  - img_out is not zeroed; its contents are don't-care while image_valid=0.
- byte_count never exceeds BYTES_PER_IMG-1; it wraps to 0 only on image completion, clear or reset.
- img_out contents are don't-care while image_valid=0.

Optional Feature:
- Macro: IMG_CHECKSUM_EN.
- Defined:
  - After the last data byte the loader enters CHECK with in_ready=1 and accepts exactly one extra byte, compared against the running XOR of all data bytes.
  - Match: go to FULL, image_valid=1.
  - Mismatch: checksum_err pulses high for one cycle, state returns to FILL with byte_count=0, image_valid stays 0.
  - The running XOR resets with byte_count, on clear and on reset.
- Undefined: no CHECK state, no XOR register, checksum_err tied to 0.

Test Plan:
- Reset, then stream 98 bytes 0x80 with in_valid held high -> image_valid=1 one cycle after the last byte; img_out[8k]=1 for every k, all other bits 0; in_ready=0.
- Full image, then img_ack pulse -> image_valid=0 and in_ready=1 next cycle; a second image of 0xFF gives img_out all ones.
- Offer a byte while FULL -> overrun=1 and img_out unchanged; clear -> overrun=0, byte_count=0, image_valid=0.
- Assert rst_n=0 after 50 bytes, mid-clock -> all outputs return to reset values immediately; a fresh 98-byte stream then completes normally.
- clear and img_ack in the same cycle while FULL -> clear wins; image_valid=0, byte_count=0, overrun=0.
- With IMG_CHECKSUM_EN: 98 bytes 0x01 plus check byte 0x00 -> FULL. Same data with check byte 0x01 -> one-cycle checksum_err, image_valid remains 0, byte_count=0.
